afe_chan_aggregator: RTL and testbench
======================================

AFE_CHAN_AGGREGATOR -- requirements
Module: afe_chan_aggregator

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of AFE acquisition channels, range 1..8.
REQ-002 SHALL have parameter IN_W, default 24: width of each raw AFE word, two's complement.
REQ-003 SHALL have parameter DATA_W, default 22: significant width of each ambient-corrected result.
REQ-004 SHALL have parameter OUT_W, default 24: width of each packed result field, with OUT_W >= DATA_W.
REQ-005 SHALL have port clk, input, 1: system clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port ch_mask, input, N_CH: enabled channels.
REQ-008 SHALL have port smp_valid, input, N_CH: one-cycle per-channel pulse meaning raw words are valid.
REQ-009 SHALL have ports led1, aled1, led2, aled2, input, N_CH*IN_W: raw words; channel i at [i*IN_W +: IN_W].
REQ-010 SHALL have port conver, input, N_CH: channel SPI conversion in progress.
REQ-011 SHALL have port frame_valid, output, 1: packed frame available.
REQ-012 SHALL have port frame_ready, input, 1: consumer (uart) accepts the frame.
REQ-013 SHALL have port frame_data, output, N_CH*2*OUT_W: packed frame.
REQ-014 SHALL have ports err_clr, input, 1; ovr_err, output, 1; drop_cnt, output, 16: overrun control and status.
REQ-015 SHALL have port alm, output, 1: conversion activity while a frame is pending.

Function
REQ-016 SHALL implement two states: COLLECT and PEND.
REQ-017 In COLLECT, smp_valid[i]&ch_mask[i] SHALL register channel i results and set got[i]; a repeated sample overwrites (latest wins).
REQ-018 Results SHALL be r2=led2-aled2 and r1=led1-aled1, computed at IN_W+1 bits, saturated to signed DATA_W, then sign-extended to OUT_W.
REQ-019 When got==ch_mask and ch_mask!=0, the state SHALL change to PEND, with frame_valid high on the next cycle (1-cycle latency after the last capture).
REQ-020 frame_data field order SHALL be channel 0 in the MSBs; per channel {r2, r1}; unmasked channels read as zero.
REQ-021 frame_data SHALL be stable while frame_valid is high.
REQ-022 frame_valid&frame_ready SHALL complete the handshake: clear got, return to COLLECT, and drop frame_valid next cycle.
REQ-023 A masked smp_valid in the handshake cycle SHALL be captured into the new frame.
REQ-024 A masked smp_valid in PEND without handshake SHALL be dropped, set ovr_err (sticky), and increment drop_cnt, saturating at 0xFFFF.
REQ-025 err_clr SHALL clear ovr_err and drop_cnt; a simultaneous drop SHALL win (ovr_err=1, drop_cnt=1).
REQ-026 With ch_mask==0 the block SHALL stay in COLLECT and never assert frame_valid.
REQ-027 A ch_mask change SHALL take effect immediately in COLLECT and be ignored in PEND.
REQ-028 alm SHALL be registered: 1 when frame_valid & |(conver&ch_mask), else 0.

Reset
REQ-029 Reset SHALL force COLLECT; got, frame_valid, frame_data, ovr_err, drop_cnt and alm SHALL be 0.
REQ-030 Reset mid-frame SHALL discard the partial frame; no frame is emitted until all enabled channels resample.

Configuration
REQ-031 Macro AFE_AMB_SUB_EN defined: results SHALL follow REQ-018.
REQ-032 Macro AFE_AMB_SUB_EN undefined: r2=led2 and r1=led1 (saturated/extended identically); aled inputs SHALL be unused.

Structure
REQ-033 Shared package afe_pkg SHALL hold the state enum, the default widths, and the saturate/sign-extend function.
REQ-034 Per-channel capture and subtract SHALL be a sub-module afe_chan_sub, instantiated N_CH times by generate.

Verification
REQ-035 Scenario: N_CH=2, mask=11, ch0 led2=1000 aled2=200 led1=500 aled1=100, then ch1 -> frame_valid 1 cycle after ch1; fields 800,400,...
REQ-036 Scenario: led2=0x7FFFFF, aled2=0x800000 -> r2 saturates to 0x1FFFFF, packed 0x1FFFFF; reverse operands -> 0xE00000.
REQ-037 Scenario: frame pending, frame_ready=0, three ch0 pulses -> ovr_err=1, drop_cnt=3; err_clr -> both 0.
REQ-038 Scenario: frame_ready and ch1 smp_valid in the same cycle -> handshake completes and got[1]=1 in the new frame.
REQ-039 Scenario: mask=01, ch1 pulses only -> no frame; conver[0]=1 during PEND -> alm=1 next cycle.
REQ-040 Scenario: rst_n low after ch0 only -> all outputs 0; ch1 then alone gives no frame.

Source files
------------

// File: rtl/afe_pkg.sv
// Shared definitions for the AFE channel aggregator: state encoding, default
// widths and the saturate/sign-extend helper.
package afe_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    PEND    = 1'b1
  } state_t;

  localparam int DEF_N_CH   = 2;
  localparam int DEF_IN_W   = 24;
  localparam int DEF_DATA_W = 22;
  localparam int DEF_OUT_W  = 24;

  // Clamp a sign-extended value into signed data_w range; the caller truncates
  // the 64-bit result to its field width, which keeps the sign extension.
  function automatic logic signed [63:0] sat_ext(input logic signed [63:0] v,
                                                 input int unsigned data_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/afe_chan_sub.sv
// One AFE channel: ambient subtraction (when AFE_AMB_SUB_EN is defined),
// saturation to DATA_W, sign extension to OUT_W, and the capture register.
module afe_chan_sub
  import afe_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_cap,
  input  logic [IN_W-1:0] i_led1,
  input  logic [IN_W-1:0] i_aled1,
  input  logic [IN_W-1:0] i_led2,
  input  logic [IN_W-1:0] i_aled2,
  output logic [OUT_W-1:0] o_r2,
  output logic [OUT_W-1:0] o_r1
);

  logic signed [IN_W:0] w_d2;
  logic signed [IN_W:0] w_d1;

`ifdef AFE_AMB_SUB_EN
  assign w_d2 = $signed({i_led2[IN_W-1], i_led2}) - $signed({i_aled2[IN_W-1], i_aled2});
  assign w_d1 = $signed({i_led1[IN_W-1], i_led1}) - $signed({i_aled1[IN_W-1], i_aled1});
`else
  logic w_aled_unused;
  assign w_aled_unused = ^{i_aled1, i_aled2};
  assign w_d2 = $signed({i_led2[IN_W-1], i_led2});
  assign w_d1 = $signed({i_led1[IN_W-1], i_led1});
`endif

  logic [OUT_W-1:0] r_r2_p0;
  logic [OUT_W-1:0] r_r1_p0;

  // p0: capture register, holds the latest accepted sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r2_p0 <= '0;
      r_r1_p0 <= '0;
    end else if (i_cap) begin
      r_r2_p0 <= OUT_W'(sat_ext(64'(w_d2), DATA_W));
      r_r1_p0 <= OUT_W'(sat_ext(64'(w_d1), DATA_W));
    end
  end

  assign o_r2 = r_r2_p0;
  assign o_r1 = r_r1_p0;

endmodule

// File: rtl/afe_chan_aggregator.sv
// Collects one result pair per enabled AFE channel into a packed frame with a
// valid/ready handshake, overrun accounting and a conversion alarm.
// Optional ambient subtraction is enabled by defining AFE_AMB_SUB_EN.
module afe_chan_aggregator
  import afe_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int IN_W   = DEF_IN_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        ch_mask,
  input  logic [N_CH-1:0]        smp_valid,
  input  logic [N_CH*IN_W-1:0]   led1,
  input  logic [N_CH*IN_W-1:0]   aled1,
  input  logic [N_CH*IN_W-1:0]   led2,
  input  logic [N_CH*IN_W-1:0]   aled2,
  input  logic [N_CH-1:0]        conver,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic [N_CH*2*OUT_W-1:0] frame_data,
  input  logic                   err_clr,
  output logic                   ovr_err,
  output logic [15:0]            drop_cnt,
  output logic                   alm
);

  state_t          r_state;
  logic [N_CH-1:0] r_got;
  logic [N_CH-1:0] r_mask;
  logic            r_fv;
  logic            r_ovr;
  logic [15:0]     r_drop;
  logic            r_alm;

  logic [N_CH-1:0] w_eff_mask;
  logic [N_CH-1:0] w_smp;
  logic [N_CH-1:0] w_cap;
  logic [N_CH-1:0] w_got_nxt;
  logic            w_hs;
  logic            w_drop;

  // The mask is frozen while a frame is pending so the frame stays coherent.
  assign w_eff_mask = (r_state == PEND) ? r_mask : ch_mask;
  assign w_hs       = r_fv & frame_ready;
  assign w_smp      = smp_valid & w_eff_mask;
  assign w_cap      = ((r_state == COLLECT) || w_hs) ? w_smp : '0;
  assign w_drop     = (r_state == PEND) && !w_hs && (|w_smp);
  assign w_got_nxt  = (r_got | w_cap) & ch_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
      r_got   <= '0;
      r_mask  <= '0;
      r_fv    <= 1'b0;
      r_ovr   <= 1'b0;
      r_drop  <= '0;
      r_alm   <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          r_got <= w_got_nxt;
          if ((ch_mask != '0) && (w_got_nxt == ch_mask)) begin
            r_state <= PEND;
            r_fv    <= 1'b1;
            r_mask  <= ch_mask;
          end
        end
        PEND: begin
          if (w_hs) begin
            r_state <= COLLECT;
            r_fv    <= 1'b0;
            r_got   <= w_cap;
          end
        end
        default: r_state <= COLLECT;
      endcase

      // A drop in the same cycle as a clear leaves a fresh count of one.
      if (w_drop && err_clr) begin
        r_ovr  <= 1'b1;
        r_drop <= 16'd1;
      end else if (err_clr) begin
        r_ovr  <= 1'b0;
        r_drop <= '0;
      end else if (w_drop) begin
        r_ovr <= 1'b1;
        if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      end

      r_alm <= r_fv & (|(conver & w_eff_mask));
    end
  end

  logic [OUT_W-1:0] w_r2 [N_CH];
  logic [OUT_W-1:0] w_r1 [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    afe_chan_sub #(
      .IN_W  (IN_W),
      .DATA_W(DATA_W),
      .OUT_W (OUT_W)
    ) u_sub (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_cap  (w_cap[g]),
      .i_led1 (led1[g*IN_W +: IN_W]),
      .i_aled1(aled1[g*IN_W +: IN_W]),
      .i_led2 (led2[g*IN_W +: IN_W]),
      .i_aled2(aled2[g*IN_W +: IN_W]),
      .o_r2   (w_r2[g]),
      .o_r1   (w_r1[g])
    );
    // Channel 0 occupies the most significant field pair.
    assign frame_data[(N_CH-1-g)*2*OUT_W +: 2*OUT_W] =
      r_mask[g] ? {w_r2[g], w_r1[g]} : '0;
  end

  assign frame_valid = r_fv;
  assign ovr_err     = r_ovr;
  assign drop_cnt    = r_drop;
  assign alm         = r_alm;

endmodule

// File: tb/tb_afe_chan_aggregator.sv
// Directed bench for afe_chan_aggregator with N_CH=2, IN_W=24, DATA_W=22, OUT_W=24.
module tb_afe_chan_aggregator;

  localparam int N_CH  = 2;
  localparam int IN_W  = 24;
  localparam int OUT_W = 24;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N_CH-1:0]         ch_mask;
  logic [N_CH-1:0]         smp_valid;
  logic [N_CH*IN_W-1:0]    led1, aled1, led2, aled2;
  logic [N_CH-1:0]         conver;
  logic                    frame_valid;
  logic                    frame_ready;
  logic [N_CH*2*OUT_W-1:0] frame_data;
  logic                    err_clr;
  logic                    ovr_err;
  logic [15:0]             drop_cnt;
  logic                    alm;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  afe_chan_aggregator #(.N_CH(2), .IN_W(24), .DATA_W(22), .OUT_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .ch_mask(ch_mask), .smp_valid(smp_valid),
    .led1(led1), .aled1(aled1), .led2(led2), .aled2(aled2), .conver(conver),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
    .err_clr(err_clr), .ovr_err(ovr_err), .drop_cnt(drop_cnt), .alm(alm)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int ch, input logic [23:0] l2, input logic [23:0] a2,
                       input logic [23:0] l1, input logic [23:0] a1);
    led2[ch*IN_W +: IN_W]  = l2;
    aled2[ch*IN_W +: IN_W] = a2;
    led1[ch*IN_W +: IN_W]  = l1;
    aled1[ch*IN_W +: IN_W] = a1;
    smp_valid      = '0;
    smp_valid[ch]  = 1'b1;
    step();
    smp_valid = '0;
  endtask

  task automatic handshake();
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ch_mask = '0; smp_valid = '0; conver = '0;
    led1 = '0; aled1 = '0; led2 = '0; aled2 = '0;
    frame_ready = 1'b0; err_clr = 1'b0;
    step(); step();
    n_checks++; if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL reset_fv got=%0b exp=0", frame_valid); end
    n_checks++; if (frame_data !== '0) begin n_errors++; $display("FAIL reset_data got=%h exp=0", frame_data); end
    n_checks++; if (ovr_err !== 1'b0) begin n_errors++; $display("FAIL reset_ovr got=%0b exp=0", ovr_err); end
    n_checks++; if (drop_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    n_checks++; if (alm !== 1'b0) begin n_errors++; $display("FAIL reset_alm got=%0b exp=0", alm); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [95:0] exp;
`ifdef AFE_AMB_SUB_EN
    exp = {24'd800, 24'd400, 24'd1500, 24'hFFFF38};
`else
    exp = {24'd1000, 24'd500, 24'd2000, 24'hFFFED4};
`endif
    ch_mask = 2'b11;
    pulse(0, 24'd1000, 24'd200, 24'd500, 24'd100);
    n_checks++; if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL basic_fv_early got=%0b exp=0", frame_valid); end
    pulse(1, 24'd2000, 24'd500, 24'hFFFED4, 24'hFFFF9C);
    n_checks++; if (frame_valid !== 1'b1) begin n_errors++; $display("FAIL basic_fv got=%0b exp=1", frame_valid); end
    n_checks++; if (frame_data !== exp) begin n_errors++; $display("FAIL basic_data got=%h exp=%h", frame_data, exp); end
    step(); step();
    n_checks++; if (frame_valid !== 1'b1) begin n_errors++; $display("FAIL basic_fv_hold got=%0b exp=1", frame_valid); end
    n_checks++; if (frame_data !== exp) begin n_errors++; $display("FAIL basic_data_stable got=%h exp=%h", frame_data, exp); end
    handshake();
    n_checks++; if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL basic_fv_drop got=%0b exp=0", frame_valid); end
  endtask

  task automatic test_saturation();
    logic [95:0] exp;
    exp = {24'h1FFFFF, 24'h1FFFFF, 24'hE00000, 24'h1FFFFF};
    pulse(0, 24'h7FFFFF, 24'h800000, 24'h200000, 24'h000000);
    pulse(1, 24'h800000, 24'h7FFFFF, 24'h1FFFFF, 24'h000000);
    n_checks++; if (frame_valid !== 1'b1) begin n_errors++; $display("FAIL sat_fv got=%0b exp=1", frame_valid); end
    n_checks++; if (frame_data !== exp) begin n_errors++; $display("FAIL sat_data got=%h exp=%h", frame_data, exp); end
    handshake();
  endtask

  task automatic test_overrun();
    logic [95:0] exp;
    exp = {24'd10, 24'd20, 24'd30, 24'd40};
    pulse(0, 24'd10, 24'd0, 24'd20, 24'd0);
    pulse(1, 24'd30, 24'd0, 24'd40, 24'd0);
    for (int k = 0; k < 3; k++) pulse(0, 24'd99, 24'd0, 24'd99, 24'd0);
    n_checks++; if (ovr_err !== 1'b1) begin n_errors++; $display("FAIL ovr_set got=%0b exp=1", ovr_err); end
    n_checks++; if (drop_cnt !== 16'd3) begin n_errors++; $display("FAIL ovr_cnt got=%0d exp=3", drop_cnt); end
    n_checks++; if (frame_data !== exp) begin n_errors++; $display("FAIL ovr_data_kept got=%h exp=%h", frame_data, exp); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
    n_checks++; if (ovr_err !== 1'b0) begin n_errors++; $display("FAIL ovr_clr got=%0b exp=0", ovr_err); end
    n_checks++; if (drop_cnt !== 16'd0) begin n_errors++; $display("FAIL ovr_cnt_clr got=%0d exp=0", drop_cnt); end
    pulse(0, 24'd99, 24'd0, 24'd99, 24'd0);
    pulse(0, 24'd99, 24'd0, 24'd99, 24'd0);
    err_clr = 1'b1;
    pulse(1, 24'd99, 24'd0, 24'd99, 24'd0);
    err_clr = 1'b0;
    n_checks++; if (ovr_err !== 1'b1) begin n_errors++; $display("FAIL ovr_clr_race got=%0b exp=1", ovr_err); end
    n_checks++; if (drop_cnt !== 16'd1) begin n_errors++; $display("FAIL ovr_cnt_race got=%0d exp=1", drop_cnt); end
    err_clr = 1'b1; step(); err_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [95:0] exp;
    exp = {24'd5, 24'd6, 24'd77, 24'd88};
    led2[IN_W +: IN_W] = 24'd77;
    led1[IN_W +: IN_W] = 24'd88;
    smp_valid = 2'b10;
    frame_ready = 1'b1;
    step();
    smp_valid = '0;
    frame_ready = 1'b0;
    n_checks++; if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_fv_drop got=%0b exp=0", frame_valid); end
    pulse(0, 24'd5, 24'd0, 24'd6, 24'd0);
    n_checks++; if (frame_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_fv got=%0b exp=1", frame_valid); end
    n_checks++; if (frame_data !== exp) begin n_errors++; $display("FAIL b2b_data got=%h exp=%h", frame_data, exp); end
    handshake();
  endtask

  task automatic test_mask_alarm();
    logic [95:0] exp;
    exp = {24'd100, 24'd50, 48'd0};
    ch_mask = 2'b01;
    for (int k = 0; k < 3; k++) pulse(1, 24'd7, 24'd0, 24'd7, 24'd0);
    step();
    n_checks++; if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL mask_nofv got=%0b exp=0", frame_valid); end
    pulse(0, 24'd100, 24'd0, 24'd50, 24'd0);
    n_checks++; if (frame_valid !== 1'b1) begin n_errors++; $display("FAIL mask_fv got=%0b exp=1", frame_valid); end
    n_checks++; if (frame_data !== exp) begin n_errors++; $display("FAIL mask_data got=%h exp=%h", frame_data, exp); end
    conver = 2'b10; step();
    n_checks++; if (alm !== 1'b0) begin n_errors++; $display("FAIL alm_unmasked got=%0b exp=0", alm); end
    conver = 2'b01; step();
    n_checks++; if (alm !== 1'b1) begin n_errors++; $display("FAIL alm_set got=%0b exp=1", alm); end
    conver = 2'b00; step();
    n_checks++; if (alm !== 1'b0) begin n_errors++; $display("FAIL alm_clr got=%0b exp=0", alm); end
    handshake();
    ch_mask = 2'b00;
    pulse(0, 24'd1, 24'd0, 24'd1, 24'd0);
    pulse(1, 24'd1, 24'd0, 24'd1, 24'd0);
    step();
    n_checks++; if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL mask0_nofv got=%0b exp=0", frame_valid); end
  endtask

  task automatic test_reset_mid();
    ch_mask = 2'b11;
    pulse(0, 24'd1, 24'd0, 24'd2, 24'd0);
    rst_n = 1'b0;
    step();
    n_checks++; if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_fv got=%0b exp=0", frame_valid); end
    n_checks++; if (frame_data !== '0) begin n_errors++; $display("FAIL rstmid_data got=%h exp=0", frame_data); end
    rst_n = 1'b1;
    step();
    pulse(1, 24'd3, 24'd0, 24'd4, 24'd0);
    step();
    n_checks++; if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_nofv got=%0b exp=0", frame_valid); end
    pulse(0, 24'd1, 24'd0, 24'd2, 24'd0);
    n_checks++; if (frame_valid !== 1'b1) begin n_errors++; $display("FAIL rstmid_refill got=%0b exp=1", frame_valid); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_overrun();
    test_back_to_back();
    test_mask_alarm();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
